// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file slice.
package register_file_pkg;
  localparam int REG_ADDR_W_DEFAULT = 3;
  localparam int DATA_W_DEFAULT     = 32;
  localparam int WR_COUNT_W         = 8;
endpackage

// File: rtl/register_file_cells.sv
// Leaf cells for the register file: regn (storage entry) and muxn (2:1 read mux).
module regn #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

module muxn #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  output logic [N-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/register_file.sv
// 2-read/1-write register file with entry 0 hardwired to zero and a saturating write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module register_file
  import register_file_pkg::*;
#(
  parameter int N      = DATA_W_DEFAULT,
  parameter int ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [N-1:0]          wdata,
  input  logic [ADDR_W-1:0]     raddr_a,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [N-1:0]          rdata_a,
  output logic [N-1:0]          rdata_b,
  output logic [WR_COUNT_W-1:0] wr_count
);
  localparam int DEPTH = 1 << ADDR_W;

  logic             accept;
  logic [DEPTH-1:0] ld;
  logic [N-1:0]     q  [DEPTH];
  logic [N-1:0]     rd [2];

  assign accept = we && (waddr != '0);

  always_comb begin
    ld = '0;
    if (accept) ld[waddr] = 1'b1;
  end

  // Entry 0 has no storage so it reads zero even before the first reset.
  assign q[0] = '0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_ent
    regn #(.N(N)) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .ld   (ld[i]),
      .d    (wdata),
      .q    (q[i])
    );
  end

  // Heap-ordered mux tree per port: node k has children 2k+1/2k+2, leaves at DEPTH-1+i,
  // so the root level selects on the address MSB.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] sel;
    logic [N-1:0]      node [2*DEPTH-1];

    assign sel = (p == 0) ? raddr_a : raddr_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_leaf
      assign node[DEPTH-1+i] = q[i];
    end

    for (genvar d = 0; d < ADDR_W; d++) begin : g_lvl
      for (genvar j = 0; j < (1 << d); j++) begin : g_node
        localparam int K = (1 << d) - 1 + j;
        muxn #(.N(N)) u_mux (
          .a  (node[2*K+1]),
          .b  (node[2*K+2]),
          .sel(sel[ADDR_W-1-d]),
          .y  (node[K])
        );
      end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd[p] = (we && (sel != '0) && (waddr == sel)) ? wdata : node[0];
`else
    assign rd[p] = node[0];
`endif
  end

  assign rdata_a = rd[0];
  assign rdata_b = rd[1];

  always_ff @(posedge clk) begin
    if (!rst_n)                         wr_count <= '0;
    else if (accept && wr_count != '1)  wr_count <= wr_count + WR_COUNT_W'(1);
  end
endmodule
